// File: rtl/imem_responder.sv
// Instruction-memory responder: a DEPTH x 32 program store that is filled
// through a byte-serial load port and then serves instruction fetches with
// one registered cycle of latency. Jump opcodes are flagged in the response
// so the fetch stage can redirect without decoding the word itself.
module imem_responder #(
  parameter int          ADDR_W  = 4,
  parameter int          DEPTH   = 16,
  parameter logic [5:0]  JUMP_OP = 6'b001110
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  output logic              load_ready,
  output logic              loaded,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_instr,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_is_jump
);

  typedef enum logic {
    LOAD  = 1'b0,
    SERVE = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] word_ptr;
  logic [1:0]        byte_cnt;
  // Only the first three bytes of a word need holding; the fourth byte is
  // taken straight from load_byte when the word is written.
  logic [23:0]       asm_word;

  logic              byte_take;
  logic              word_done;
  logic              fetch_take;

  // Next-state decode, load/fetch handshakes and the combinational fetch_ready.
  always_comb begin
    state_next  = state;
    byte_take   = 1'b0;
    word_done   = 1'b0;
    fetch_take  = 1'b0;
    fetch_ready = 1'b0;
    case (state)
      LOAD: begin
        if (load_start) begin
          // Restart wins over any byte presented in the same cycle.
          state_next = LOAD;
        end else begin
          byte_take = load_valid & load_ready;
          word_done = byte_take & (byte_cnt == 2'd3);
          if (word_done && (word_ptr == ADDR_W'(DEPTH - 1))) begin
            state_next = SERVE;
          end else begin
            state_next = LOAD;
          end
        end
      end
      SERVE: begin
        // Single-entry output register: accept only if it is empty or draining.
        fetch_ready = ~rsp_valid | rsp_ready;
        fetch_take  = fetch_req & fetch_ready & ~load_start;
        if (load_start) begin
          state_next = LOAD;
        end else begin
          state_next = SERVE;
        end
      end
      default: begin
        state_next = LOAD;
      end
    endcase
  end

  // FSM state plus the status flags that mirror it one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOAD;
      load_ready <= 1'b0;
      loaded     <= 1'b0;
    end else begin
      state      <= state_next;
      load_ready <= (state_next == LOAD);
      loaded     <= (state_next == SERVE);
    end
  end

  // Byte assembly and word/byte pointers; any load_start restarts at word 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_ptr <= '0;
      byte_cnt <= 2'd0;
      asm_word <= 24'd0;
    end else if (load_start) begin
      word_ptr <= '0;
      byte_cnt <= 2'd0;
    end else if (byte_take) begin
      asm_word <= {asm_word[15:0], load_byte};
      byte_cnt <= byte_cnt + 2'd1;
      if (word_done) begin
        word_ptr <= word_ptr + ADDR_W'(1);
      end
    end
  end

  // Program store write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (word_done) begin
      mem[word_ptr] <= {asm_word, load_byte};
    end
  end

  // Response register: load on accept, drop valid on consume, hold on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid   <= 1'b0;
      rsp_instr   <= 32'd0;
      rsp_addr    <= '0;
      rsp_is_jump <= 1'b0;
    end else if (load_start) begin
      rsp_valid <= 1'b0;
    end else if (fetch_take) begin
      rsp_valid   <= 1'b1;
      rsp_instr   <= mem[fetch_addr];
      rsp_addr    <= fetch_addr;
      rsp_is_jump <= (mem[fetch_addr][31:26] == JUMP_OP);
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder: the memory-side end of the instruction-fetch interface.
- Holds a DEPTH x 32 program store, filled through a byte-serial load port after reset.
- Once the store is full, it answers fetch requests with one registered cycle of latency and a valid/ready response.
- It also flags jump opcodes (op = 6'b001110), so the fetch stage can redirect without decoding.

Parameters:
- ADDR_W, 4, fetch address width in words
- DEPTH, 16, number of 32-bit instruction words; must equal 2**ADDR_W
- JUMP_OP, 6'b001110, opcode value in bits [31:26] that sets rsp_is_jump

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- load_start  input  1  one-cycle pulse; restarts program load from word 0
- load_valid  input  1  load_byte is valid this cycle
- load_byte  input  8  program byte, big-endian within each word
- load_ready  output  1  block accepts a load byte this cycle
- loaded  output  1  store is full and fetch service is enabled
- fetch_req  input  1  fetch request
- fetch_addr  input  ADDR_W  word address to fetch
- fetch_ready  output  1  request accepted when fetch_req & fetch_ready
- rsp_valid  output  1  response valid
- rsp_ready  input  1  fetch stage consumes the response
- rsp_instr  output  32  instruction word
- rsp_addr  output  ADDR_W  address that produced rsp_instr
- rsp_is_jump  output  1  rsp_instr[31:26] == JUMP_OP

Behaviour:
- Reset is asynchronous on rst_n low.
  - All outputs go to 0: load_ready, loaded, fetch_ready, rsp_valid, rsp_instr, rsp_addr, rsp_is_jump.
  - Internal pointers: word_ptr=0, byte_cnt=0.
  - State goes to LOAD.
  - Memory contents are not reset.
- On the first clock after rst_n deasserts, load_ready=1.
- States are LOAD and SERVE.
- LOAD state:
  - load_ready=1, fetch_ready=0, rsp_valid=0.
  - Each cycle with load_valid=1, load_byte is shifted into a 32-bit assembly register, first byte landing in [31:24], and byte_cnt increments.
  - On the 4th byte (byte_cnt==3), the assembled word is written to mem[word_ptr], byte_cnt wraps to 0, and word_ptr increments.
  - When the word at word_ptr==DEPTH-1 is written, the next state is SERVE, loaded=1, load_ready=0 and word_ptr wraps to 0.
  - load_start in LOAD clears byte_cnt and word_ptr. A byte arriving in the same cycle is dropped, and load_start wins. Words already written stay in memory.
- SERVE state:
  - load_valid is ignored and load_ready=0.
  - fetch_ready = !rsp_valid | rsp_ready, a single-entry output register with no skid buffer.
  - On fetch_req & fetch_ready, on the next clock: rsp_valid=1, rsp_instr=mem[fetch_addr], rsp_addr=fetch_addr, and rsp_is_jump from rsp_instr[31:26].
  - Latency is exactly 1 cycle from the accepting edge.
  - If rsp_valid & rsp_ready and there is no new accept, rsp_valid goes to 0 next cycle. rsp_instr and rsp_addr hold their last values.
  - If rsp_valid & !rsp_ready, all rsp_* outputs hold stable and fetch_ready=0.
  - Back-to-back throughput is 1 response per cycle when rsp_ready stays high.
- load_start in SERVE:
  - Next state is LOAD, loaded=0, and rsp_valid drops to 0 next cycle.
  - A pending response is discarded, and a fetch accepted in the same cycle is discarded.
- Addresses are ADDR_W bits with no range check; fetch_addr=4'hF reads the last word.
- Simultaneous load_start and rst_n low: reset dominates.

Test Plan:
- Reset then load 64 bytes giving mem[k]=32'h0000_0000+k (bytes 00,00,00,k) -> loaded rises on the clock after the 64th byte; load_ready=0 after that.
- SERVE with rsp_ready=1: fetch addr 3, 4, 5 on consecutive cycles -> rsp_valid high on 3 consecutive cycles with rsp_instr 3, 4, 5 and rsp_addr 3, 4, 5, each one cycle after its accept.
- Backpressure: fetch addr 2, then rsp_ready=0 for 3 cycles -> rsp_instr=2 held, fetch_ready=0 throughout; rsp_ready=1 -> response consumed and fetch_ready=1.
- Jump flag: load word 15 as 32'h3800_0002 (op 001110), fetch addr 15 -> rsp_is_jump=1; fetch addr 0 -> rsp_is_jump=0.
- load_start with an outstanding unconsumed response -> rsp_valid=0 next cycle, loaded=0, load_ready=1. A reload of 64 bytes with new data then returns the new word on fetch addr 0.
- Assert rst_n low mid-load after 2 bytes of word 5 -> all outputs 0 immediately. After release, a load restarts at word 0 with byte_cnt=0, checked by a fetch after a full reload.
